// File: rtl/ps2_pkg.sv
// Shared scancode constants, frame-state encoding and key-event record
// for the PS/2 receive path.
package ps2_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } frame_state_t;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ps2_ev_t;

endpackage

// File: rtl/ps2_ev_fifo.sv
// Key-event FIFO with valid/ready read side. A push into a full FIFO is
// accepted only if the head is popped in the same cycle; otherwise it is dropped.
module ps2_ev_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_wr,
    input  logic [9:0] i_data,
    input  logic       i_ready,
    output logic [9:0] o_data,
    output logic       o_valid,
    output logic       o_drop
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DEPTH_LOG2:0] r_wr_ptr;
    logic [DEPTH_LOG2:0] r_rd_ptr;
    logic [9:0]          r_mem [DEPTH];
    logic                w_full;
    logic                w_pop;
    logic                w_push;

    assign o_valid = (r_wr_ptr != r_rd_ptr);
    assign w_full  = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                     (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
    assign w_pop   = o_valid && i_ready;
    assign w_push  = i_wr && (!w_full || w_pop);
    assign o_drop  = i_wr && !w_push;
    assign o_data  = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= i_data;
                r_wr_ptr <= r_wr_ptr + (DEPTH_LOG2+1)'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + (DEPTH_LOG2+1)'(1);
        end
    end

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: synchronise, deframe and check 11-bit frames, fold
// E0/F0 prefixes into one key event, and queue events for the text buffer.
module ps2_scan_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT    = 200000,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_brk,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic       shift_held,
    output logic       overflow,
    output logic [7:0] err_cnt
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [2:0]      r_clk_sync;
    logic [2:0]      r_dat_sync;
    frame_state_t    r_state;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic            r_par;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_byte_vld;
    logic [7:0]      r_byte;
    logic            r_ext_f;
    logic            r_brk_f;
    logic            r_lsh;
    logic            r_rsh;
    logic            r_ovf;
    logic [7:0]      r_err;

    logic            w_sample;
    logic            w_bit;
    logic            w_timeout;
    logic            w_stop;
    logic            w_good;
    logic            w_is_ev;
    logic            w_drop;
    logic [9:0]      w_head_raw;
    ps2_ev_t         w_ev;
    ps2_ev_t         w_head;

    // Index 0 is the pad-side flop; the edge is seen between stages 2 and 1.
    assign w_sample  = r_clk_sync[2] & ~r_clk_sync[1];
    assign w_bit     = r_dat_sync[2];
    assign w_timeout = (r_state != ST_IDLE) && (r_to_cnt == TO_W'(TIMEOUT));
    assign w_stop    = w_sample && !w_timeout && (r_state == ST_STOP);
    assign w_good    = w_bit && (^{r_shift, r_par});
    assign w_is_ev   = r_byte_vld && (r_byte != SC_EXT) && (r_byte != SC_BRK);
    assign w_ev      = '{code: r_byte, ext: r_ext_f, brk: r_brk_f};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_sync <= '0;
            r_dat_sync <= '0;
        end else begin
            r_clk_sync <= {r_clk_sync[1:0], ps2_clk};
            r_dat_sync <= {r_dat_sync[1:0], ps2_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_to_cnt   <= '0;
            r_byte_vld <= 1'b0;
            r_byte     <= '0;
        end else begin
            r_byte_vld <= 1'b0;
            if (w_sample || r_state == ST_IDLE)
                r_to_cnt <= '0;
            else if (r_to_cnt != TO_W'(TIMEOUT))
                r_to_cnt <= r_to_cnt + TO_W'(1);

            if (w_timeout) begin
                r_state <= ST_IDLE;
            end else if (w_sample) begin
                case (r_state)
                    ST_IDLE: if (!w_bit) begin
                        r_state   <= ST_DATA;
                        r_bit_cnt <= '0;
                    end
                    ST_DATA: begin
                        r_shift   <= {w_bit, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) r_state <= ST_PAR;
                    end
                    ST_PAR: begin
                        r_par   <= w_bit;
                        r_state <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (w_good) begin
                            r_byte_vld <= 1'b1;
                            r_byte     <= r_shift;
                        end
                        r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ext_f <= 1'b0;
            r_brk_f <= 1'b0;
            r_lsh   <= 1'b0;
            r_rsh   <= 1'b0;
            r_ovf   <= 1'b0;
            r_err   <= '0;
        end else begin
            if ((w_stop && !w_good) || w_timeout) begin
                r_ext_f <= 1'b0;
                r_brk_f <= 1'b0;
                if (w_stop && !w_good && r_err != 8'hFF) r_err <= r_err + 8'd1;
            end else if (r_byte_vld) begin
                if (r_byte == SC_EXT) begin
                    r_ext_f <= 1'b1;
                end else if (r_byte == SC_BRK) begin
                    r_brk_f <= 1'b1;
                end else begin
                    r_ext_f <= 1'b0;
                    r_brk_f <= 1'b0;
                    // Shift state follows the key even when the FIFO drops the event.
                    if (!r_ext_f && r_byte == SC_LSHIFT) r_lsh <= !r_brk_f;
                    if (!r_ext_f && r_byte == SC_RSHIFT) r_rsh <= !r_brk_f;
                end
            end
            if (w_drop) r_ovf <= 1'b1;
        end
    end

    ps2_ev_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_wr    (w_is_ev),
        .i_data  (w_ev),
        .i_ready (ev_ready),
        .o_data  (w_head_raw),
        .o_valid (ev_valid),
        .o_drop  (w_drop)
    );

    assign w_head     = ps2_ev_t'(w_head_raw);
    assign ev_code    = w_head.code;
    assign ev_ext     = w_head.ext;
    assign ev_brk     = w_head.brk;
    assign shift_held = r_lsh | r_rsh;
    assign overflow   = r_ovf;
    assign err_cnt    = r_err;

endmodule
